// File: rtl/sdp_chn_in_rsci_buf.sv
// Input-channel skid buffer between the upstream valid/ready stream and the core.
// A DEPTH-entry FIFO with registered ready, a one-cycle fill latency and a synchronous flush.
module sdp_chn_in_rsci_buf #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [WIDTH-1:0] chn_in_rsc_z,
    input  logic             chn_in_rsc_vz,
    output logic             chn_in_rsc_lz,
    input  logic             chn_in_rsci_oswt,
    input  logic             core_wen,
    input  logic             chn_in_rsci_clr,
    output logic             chn_in_rsci_bawt,
    output logic             chn_in_rsci_wen_comp,
    output logic [WIDTH-1:0] chn_in_rsci_d_mxwt,
    output logic [CNT_W-1:0] chn_in_rsci_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             push;
    logic             pop;

    // Ready depends only on the occupancy register, so a pop never opens the
    // door for a push in the same cycle; a full buffer refuses until cnt drops.
    assign chn_in_rsc_lz        = (cnt < CNT_FULL);
    assign chn_in_rsci_bawt     = (cnt != '0);
    assign chn_in_rsci_wen_comp = ~chn_in_rsci_oswt | chn_in_rsci_bawt;
    assign chn_in_rsci_cnt      = cnt;
    assign chn_in_rsci_d_mxwt   = chn_in_rsci_bawt ? mem[rd_ptr] : '0;

    assign push = chn_in_rsc_vz & chn_in_rsc_lz & ~chn_in_rsci_clr;
    assign pop  = chn_in_rsci_oswt & core_wen & chn_in_rsci_bawt & ~chn_in_rsci_clr;

    // NOTE: every signal assigned in always_comb gets a default on entry so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        if (chn_in_rsci_clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            cnt_nxt    = '0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths inside the array.
            if (push) begin
                wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_nxt = cnt + CNT_ONE;
                2'b01:   cnt_nxt = cnt - CNT_ONE;
                default: cnt_nxt = cnt;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable once
    // cnt is zero, and leaving it out keeps the array a plain register file.
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr] <= chn_in_rsc_z;
        end
    end

endmodule

// File: tb/tb_sdp_chn_in_rsci_buf.sv
// Directed and randomized scoreboard bench for sdp_chn_in_rsci_buf (DEPTH=2 and DEPTH=3 instances).
module tb_sdp_chn_in_rsci_buf;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=2
    logic [W-1:0] a_z = '0;
    logic         a_vz = 1'b0, a_oswt = 1'b0, a_wen = 1'b0, a_clr = 1'b0;
    logic         a_lz, a_bawt, a_wc;
    logic [W-1:0] a_d;
    logic [1:0]   a_cnt;

    // Instance B: DEPTH=3
    logic [W-1:0] b_z = '0;
    logic         b_vz = 1'b0, b_oswt = 1'b0, b_wen = 1'b0, b_clr = 1'b0;
    logic         b_lz, b_bawt, b_wc;
    logic [W-1:0] b_d;
    logic [1:0]   b_cnt;

    sdp_chn_in_rsci_buf #(.WIDTH(W), .DEPTH(2), .CNT_W(2)) dut_a (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .chn_in_rsc_z(a_z), .chn_in_rsc_vz(a_vz), .chn_in_rsc_lz(a_lz),
        .chn_in_rsci_oswt(a_oswt), .core_wen(a_wen), .chn_in_rsci_clr(a_clr),
        .chn_in_rsci_bawt(a_bawt), .chn_in_rsci_wen_comp(a_wc),
        .chn_in_rsci_d_mxwt(a_d), .chn_in_rsci_cnt(a_cnt)
    );

    sdp_chn_in_rsci_buf #(.WIDTH(W), .DEPTH(3), .CNT_W(2)) dut_b (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .chn_in_rsc_z(b_z), .chn_in_rsc_vz(b_vz), .chn_in_rsc_lz(b_lz),
        .chn_in_rsci_oswt(b_oswt), .core_wen(b_wen), .chn_in_rsci_clr(b_clr),
        .chn_in_rsci_bawt(b_bawt), .chn_in_rsci_wen_comp(b_wc),
        .chn_in_rsci_d_mxwt(b_d), .chn_in_rsci_cnt(b_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of instance A: drive, check against the scoreboard before the
    // edge, then retire the predicted push/pop once the edge has passed.
    task automatic cyc_a(input logic vz, input logic [W-1:0] data, input logic oswt,
                         input logic wen, input logic clr);
        logic do_push, do_pop;
        a_vz = vz; a_z = data; a_oswt = oswt; a_wen = wen; a_clr = clr;
        #1;
        check("a_lz",   W'(a_lz),   W'(qa.size() < 2));
        check("a_bawt", W'(a_bawt), W'(qa.size() != 0));
        check("a_wc",   W'(a_wc),   W'(!oswt || qa.size() != 0));
        check("a_cnt",  W'(a_cnt),  W'(qa.size()));
        check("a_d",    a_d,        (qa.size() != 0) ? qa[0] : '0);
        do_pop  = oswt && wen && qa.size() != 0 && !clr;
        do_push = vz && qa.size() < 2 && !clr;
        @(posedge clk); #1;
        if (clr) qa.delete();
        else begin
            if (do_pop) void'(qa.pop_front());
            if (do_push) qa.push_back(data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, popped, cycles;
        logic do_push, do_pop;

        // Reset state, including wen_comp following ~oswt while held in reset.
        #12;
        check("rst_cnt",  W'(a_cnt),  0);
        check("rst_lz",   W'(a_lz),   1);
        check("rst_bawt", W'(a_bawt), 0);
        check("rst_d",    a_d,        0);
        check("rst_wc0",  W'(a_wc),   1);
        a_oswt = 1'b1; #1;
        check("rst_wc1",  W'(a_wc),   0);
        a_oswt = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic transfer
        cyc_a(1, 32'hA5, 0, 1, 0);
        check("bt_bawt", W'(a_bawt), 1);
        check("bt_d",    a_d,        32'hA5);
        check("bt_cnt",  W'(a_cnt),  1);
        cyc_a(0, 0, 1, 1, 0);
        check("bt_cnt0", W'(a_cnt),  0);
        check("bt_d0",   a_d,        0);

        // Fill and backpressure, then full with same-cycle pop
        cyc_a(1, 1, 0, 0, 0);
        cyc_a(1, 2, 0, 0, 0);
        check("fb_cnt2", W'(a_cnt), 2);
        check("fb_lz0",  W'(a_lz),  0);
        cyc_a(1, 3, 0, 0, 0);
        cyc_a(1, 3, 0, 0, 0);
        check("fb_hold", W'(a_cnt), 2);
        cyc_a(1, 3, 1, 1, 0);
        check("fp_cnt1", W'(a_cnt), 1);
        check("fp_lz1",  W'(a_lz),  1);
        check("fp_head", a_d,       2);
        cyc_a(1, 3, 1, 1, 0);
        check("fb_same", W'(a_cnt), 1);
        check("fb_h3",   a_d,       3);
        cyc_a(0, 0, 1, 1, 0);
        check("fb_empty", W'(a_cnt), 0);

        // Stall
        cyc_a(0, 0, 1, 0, 0);
        check("st_wc0", W'(a_wc), 0);
        cyc_a(1, 7, 1, 0, 0);
        check("st_wc1", W'(a_wc),  1);
        check("st_d7",  a_d,       7);
        cyc_a(0, 0, 1, 0, 0);
        cyc_a(0, 0, 1, 0, 0);
        check("st_nopop", W'(a_cnt), 1);
        cyc_a(0, 0, 1, 1, 0);
        check("st_pop", W'(a_cnt), 0);

        // Flush at full and at partial occupancy
        cyc_a(1, 32'h11, 0, 0, 0);
        cyc_a(1, 32'h22, 0, 0, 0);
        cyc_a(1, 32'h33, 1, 1, 1);
        check("fl_cnt",  W'(a_cnt),  0);
        check("fl_bawt", W'(a_bawt), 0);
        cyc_a(1, 32'h44, 0, 0, 0);
        cyc_a(1, 32'h55, 0, 0, 1);
        check("fl_cnt1", W'(a_cnt), 0);
        check("fl_d",    a_d,       0);

        // Asynchronous reset mid-transfer, then first push right after release
        cyc_a(1, 32'h66, 0, 0, 0);
        a_vz = 1'b0;
        check("ar_pre", W'(a_cnt), 1);
        #2; rst_n = 1'b0; #1;
        check("ar_cnt",  W'(a_cnt),  0);
        check("ar_bawt", W'(a_bawt), 0);
        check("ar_lz",   W'(a_lz),   1);
        qa.delete(); qb.delete();
        #2; rst_n = 1'b1;
        cyc_a(1, 32'h77, 0, 0, 0);
        check("ar_first", W'(a_cnt), 1);
        cyc_a(0, 0, 1, 1, 0);

        // Wrap with DEPTH=3: random valid/read, order and bound checked
        pushed = 0; popped = 0; cycles = 0;
        while (popped < 10 && cycles < 400) begin
            b_vz   = (pushed < 10) && ($urandom_range(0, 2) != 0);
            b_z    = 32'h100 + W'(pushed);
            b_oswt = ($urandom_range(0, 2) != 0);
            b_wen  = ($urandom_range(0, 3) != 0);
            b_clr  = 1'b0;
            #1;
            check("wr_cnt",  W'(b_cnt),            W'(qb.size()));
            check("wr_max",  W'(b_cnt <= 2'd3 && qb.size() <= 3), 1);
            check("wr_lz",   W'(b_lz),             W'(qb.size() < 3));
            check("wr_d",    b_d,                  (qb.size() != 0) ? qb[0] : '0);
            do_pop  = b_oswt && b_wen && qb.size() != 0;
            do_push = b_vz && qb.size() < 3;
            @(posedge clk); #1;
            if (do_pop) begin void'(qb.pop_front()); popped++; end
            if (do_push) begin qb.push_back(b_z); pushed++; end
            cycles++;
        end
        b_vz = 1'b0; b_oswt = 1'b0; b_wen = 1'b0;
        check("wr_done", W'(popped), 10);
        check("wr_end_cnt", W'(b_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_chn_in_rsci_buf.md
SDP_CHN_IN_RSCI_BUF -- requirements
Module: sdp_chn_in_rsci_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 512: channel data width in bits.
REQ-002 SHALL have parameter DEPTH, default 2: buffer entries; legal range 1..16.
REQ-003 SHALL have parameter CNT_W, default 2: occupancy width; SHALL be at least clog2(DEPTH+1).
REQ-004 SHALL have port nvdla_core_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nvdla_core_rstn, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 SHALL have port chn_in_rsc_z, input, WIDTH bits: upstream data.
REQ-007 SHALL have port chn_in_rsc_vz, input, 1 bit: upstream valid.
REQ-008 SHALL have port chn_in_rsc_lz, output, 1 bit: ready to upstream.
REQ-009 SHALL have port chn_in_rsci_oswt, input, 1 bit: core read request.
REQ-010 SHALL have port core_wen, input, 1 bit: core enable; a pop requires it high.
REQ-011 SHALL have port chn_in_rsci_clr, input, 1 bit: synchronous flush.
REQ-012 SHALL have port chn_in_rsci_bawt, output, 1 bit: head data available.
REQ-013 SHALL have port chn_in_rsci_wen_comp, output, 1 bit: core may proceed.
REQ-014 SHALL have port chn_in_rsci_d_mxwt, output, WIDTH bits: head-of-buffer data.
REQ-015 SHALL have port chn_in_rsci_cnt, output, CNT_W bits: current occupancy.

Function
REQ-016 SHALL implement a DEPTH-entry FIFO with write pointer, read pointer and occupancy count cnt.
REQ-017 SHALL drive chn_in_rsc_lz = (cnt < DEPTH) from registered state only; no combinational path from oswt/core_wen.
REQ-018 SHALL define push = chn_in_rsc_vz & chn_in_rsc_lz & ~chn_in_rsci_clr; data is written at the tail on that edge.
REQ-019 SHALL drive chn_in_rsci_bawt = (cnt != 0).
REQ-020 SHALL define pop = chn_in_rsci_oswt & core_wen & chn_in_rsci_bawt & ~chn_in_rsci_clr.
REQ-021 SHALL drive chn_in_rsci_wen_comp = ~chn_in_rsci_oswt | chn_in_rsci_bawt (combinational).
REQ-022 SHALL drive chn_in_rsci_d_mxwt = head entry when cnt != 0, otherwise all zeros.
REQ-023 SHALL have latency of 1 cycle: data pushed at edge N is visible on d_mxwt, with bawt=1, after edge N; no same-cycle bypass.
REQ-024 SHALL update cnt by +1 on push only, -1 on pop only, and hold it on push and pop in the same cycle.
REQ-025 SHALL, on simultaneous push and pop with 0 < cnt < DEPTH, keep cnt unchanged and preserve FIFO order.
REQ-026 SHALL, when full, refuse the push even if a pop occurs in the same cycle; lz returns to 1 the cycle after the pop.
REQ-027 SHALL wrap both pointers from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-028 SHALL, when chn_in_rsci_clr=1, reset pointers and cnt to 0 on that edge; any concurrent push or pop is discarded.
REQ-029 SHALL drive chn_in_rsci_cnt = cnt directly from the register.
REQ-030 SHALL treat pop when empty as a no-op, with no pointer movement and no underflow.

Reset
REQ-031 SHALL, while nvdla_core_rstn=0, asynchronously force pointers and cnt to 0, so that lz=1, bawt=0, d_mxwt=0, cnt=0 and wen_comp = ~oswt.
REQ-032 SHALL, when reset asserts mid-transfer, lose all buffered entries; storage contents need not reset.
REQ-033 SHALL make first push possible on the first rising edge after rstn deassertion.

Verification
REQ-034 Bench SHALL cover basic transfer: DEPTH=2; push 0xA5 with oswt=0 -> next cycle bawt=1, d_mxwt=0xA5, cnt=1; then oswt=1, core_wen=1 -> cnt=0 and d_mxwt=0 the cycle after.
REQ-035 Bench SHALL cover fill and backpressure: push 1, 2 with no pop -> cnt=2, lz=0; with vz held at 1 and data 3 offered, 3 is not accepted until after a pop; pops then return 1, 2, 3 in order.
REQ-036 Bench SHALL cover full with same-cycle pop: at cnt=2, pop with vz=1 -> cnt=1, the offered word is not taken, lz=1 next cycle.
REQ-037 Bench SHALL cover stall: with cnt=0, oswt=1 -> wen_comp=0; push 0x7 -> wen_comp=1 one cycle later; pop occurs only when core_wen=1.
REQ-038 Bench SHALL cover flush and reset: at cnt=2, clr=1 with vz=1 -> cnt=0, bawt=0 next cycle, no word accepted; asserting rstn=0 at cnt=1 -> cnt=0 immediately without a clock edge.
REQ-039 Bench SHALL cover wrap with DEPTH=3: stream 10 words with random oswt/vz -> output order equals input order and cnt never exceeds 3.
